text_ram_arbiter: RTL and testbench

Single-port text-RAM front end sitting directly upstream of the display controller's `textRamRequest`/`textRamResult` path. Arbitrates each cycle between renderer reads and terminal-engine character writes, which arrive through a small write FIFO. Renderer reads get priority. A streak limiter guarantees that buffered writes drain even under continuous rendering.

---
 rtl/text_ram_arbiter_pkg.sv | 25 ++
 rtl/text_ram_arbiter_if.sv | 30 +++
 rtl/text_ram_arbiter_write_fifo.sv | 70 +++++++
 rtl/text_ram_arbiter.sv | 126 ++++++++++++
 tb/tb_text_ram_arbiter.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/text_ram_arbiter_pkg.sv
// Shared types and constants for the text-RAM arbiter: cell geometry, cell word
// layout and the per-cycle grant encoding.
package text_ram_arbiter_pkg;

  localparam int unsigned TEXT_COLS   = 80;
  localparam int unsigned TEXT_ROWS   = 50;
  localparam int unsigned TEXT_CELLS  = TEXT_COLS * TEXT_ROWS;
  localparam int unsigned TEXT_ADDR_W = 12;
  localparam int unsigned TEXT_DATA_W = 24;

  typedef logic [TEXT_ADDR_W-1:0] TextRamAddress_t;
  typedef logic [TEXT_DATA_W-1:0] TextRamData_t;

  typedef struct packed {
    TextRamAddress_t addr;
    TextRamData_t    data;
  } TextWriteEntry_t;

  typedef enum logic [1:0] {
    GRANT_IDLE  = 2'd0,
    GRANT_READ  = 2'd1,
    GRANT_WRITE = 2'd2
  } grant_t;

endpackage

// File: rtl/text_ram_arbiter_if.sv
// Bundle of the writer, renderer and RAM-side signals around the text-RAM arbiter.
// The arbiter takes the slave view; the surrounding logic drives the master view.
interface text_ram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 24
);
  logic                  wrValid;
  logic                  wrReady;
  logic [ADDR_WIDTH-1:0] wrAddr;
  logic [DATA_WIDTH-1:0] wrData;
  logic                  rdValid;
  logic                  rdReady;
  logic [ADDR_WIDTH-1:0] rdAddr;
  logic                  rdDataValid;
  logic [DATA_WIDTH-1:0] rdData;
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic [DATA_WIDTH-1:0] ramWrData;
  logic                  ramWe;
  logic [DATA_WIDTH-1:0] ramRdData;

  modport master (
    output wrValid, wrAddr, wrData, rdValid, rdAddr, ramRdData,
    input  wrReady, rdReady, rdDataValid, rdData, ramAddr, ramWrData, ramWe
  );

  modport slave (
    input  wrValid, wrAddr, wrData, rdValid, rdAddr, ramRdData,
    output wrReady, rdReady, rdDataValid, rdData, ramAddr, ramWrData, ramWe
  );
endinterface

// File: rtl/text_ram_arbiter_write_fifo.sv
// Synchronous write FIFO holding pending cell writes (address + data).
// With TEXT_RAM_WR_COALESCE_EN defined, the newest entry's data can be overwritten in place.
module text_write_fifo #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [ADDR_WIDTH-1:0]   push_addr,
  input  logic [DATA_WIDTH-1:0]   push_data,
`ifdef TEXT_RAM_WR_COALESCE_EN
  input  logic                    overwrite,
  output logic [ADDR_WIDTH-1:0]   tail_addr,
`endif
  output logic [ADDR_WIDTH-1:0]   head_addr,
  output logic [DATA_WIDTH-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;

  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
  assign full      = (count == CNT_W'(DEPTH));

`ifdef TEXT_RAM_WR_COALESCE_EN
  logic [PTR_W-1:0] tail_ptr;
  assign tail_ptr  = wr_ptr - PTR_W'(1);
  assign tail_addr = addr_mem[tail_ptr];
`endif

  // Entry storage carries no reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
`ifdef TEXT_RAM_WR_COALESCE_EN
    else if (overwrite) begin
      data_mem[tail_ptr] <= push_data;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/text_ram_arbiter.sv
// Single-port text-RAM front end: renderer reads win, buffered terminal writes drain
// at least once per MAX_READ_STREAK reads. Optional write coalescing: TEXT_RAM_WR_COALESCE_EN.
module text_ram_arbiter
  import text_ram_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 12,
  parameter int unsigned DATA_WIDTH      = 24,
  parameter int unsigned FIFO_DEPTH      = 8,
  parameter int unsigned MAX_READ_STREAK = 15
) (
  input  logic               clk,
  input  logic               rst,
  text_ram_arbiter_if.slave  bus
);
  localparam int unsigned CNT_W    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned STREAK_W = $clog2(MAX_READ_STREAK + 1);

  grant_t                grant;
  logic [STREAK_W-1:0]   streak;
  logic                  rd_pending;
  logic [ADDR_WIDTH-1:0] last_addr;
  logic [DATA_WIDTH-1:0] last_wr_data;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wr_data;

  logic                  push;
  logic                  pop;
  logic                  wr_ready;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  assign fifo_empty = (fifo_count == '0);
  assign pop        = (grant == GRANT_WRITE);

`ifdef TEXT_RAM_WR_COALESCE_EN
  logic [ADDR_WIDTH-1:0] tail_addr;
  logic                  tail_hit;
  logic                  overwrite;

  // The tail is only safe to rewrite when it is not the head leaving this cycle.
  assign tail_hit  = !fifo_empty && (tail_addr == bus.wrAddr)
                   && !(pop && (fifo_count == CNT_W'(1)));
  assign wr_ready  = !rst && (!fifo_full || tail_hit);
  assign overwrite = bus.wrValid && wr_ready && tail_hit;
  assign push      = bus.wrValid && wr_ready && !tail_hit;
`else
  assign wr_ready  = !rst && !fifo_full;
  assign push      = bus.wrValid && wr_ready;
`endif

  text_write_fifo #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_addr (bus.wrAddr),
    .push_data (bus.wrData),
`ifdef TEXT_RAM_WR_COALESCE_EN
    .overwrite (overwrite),
    .tail_addr (tail_addr),
`endif
    .head_addr (head_addr),
    .head_data (head_data),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // Grant: reads first unless the streak limit is hit with writes waiting.
  always_comb begin
    grant = GRANT_IDLE;
    if (!rst) begin
      if (bus.rdValid && (fifo_empty || (streak < STREAK_W'(MAX_READ_STREAK))))
        grant = GRANT_READ;
      else if (!fifo_empty)
        grant = GRANT_WRITE;
    end
  end

  // RAM port: idle cycles keep presenting the last address and write data.
  always_comb begin
    ram_addr    = last_addr;
    ram_wr_data = last_wr_data;
    case (grant)
      GRANT_READ:  ram_addr = bus.rdAddr;
      GRANT_WRITE: begin
        ram_addr    = head_addr;
        ram_wr_data = head_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak       <= '0;
      rd_pending   <= 1'b0;
      last_addr    <= '0;
      last_wr_data <= '0;
    end else begin
      rd_pending <= (grant == GRANT_READ);
      if (grant != GRANT_IDLE) last_addr <= ram_addr;
      if (grant == GRANT_WRITE) last_wr_data <= ram_wr_data;
      if (fifo_empty || (grant == GRANT_WRITE))
        streak <= '0;
      else if ((grant == GRANT_READ) && (streak < STREAK_W'(MAX_READ_STREAK)))
        streak <= streak + STREAK_W'(1);
    end
  end

  assign bus.wrReady     = wr_ready;
  assign bus.rdReady     = (grant == GRANT_READ);
  assign bus.ramWe       = (grant == GRANT_WRITE);
  assign bus.ramAddr     = ram_addr;
  assign bus.ramWrData   = ram_wr_data;
  assign bus.rdDataValid = rd_pending;
  // The RAM q already carries its one-cycle latency, so read data passes straight through.
  assign bus.rdData      = rd_pending ? bus.ramRdData : '0;

endmodule

// File: tb/tb_text_ram_arbiter.sv
// Directed bench for text_ram_arbiter with a registered-output RAM model and a log of
// every RAM write; expectations follow TEXT_RAM_WR_COALESCE_EN where behaviour differs.
module tb_text_ram_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   n;
  int   reads;
  int   base;

  logic [23:0] mem [4096];
  logic        pre_we   = 1'b0;
  logic [11:0] pre_addr = '0;
  logic [23:0] pre_data = '0;
  logic [11:0] wlog_addr [$];
  logic [23:0] wlog_data [$];

  text_ram_arbiter_if #(.ADDR_WIDTH(12), .DATA_WIDTH(24)) bus ();

  text_ram_arbiter #(
    .ADDR_WIDTH      (12),
    .DATA_WIDTH      (24),
    .FIFO_DEPTH      (8),
    .MAX_READ_STREAK (15)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // RAM with one-cycle registered read data, plus a write log.
  always @(posedge clk) begin
    if (pre_we) mem[pre_addr] <= pre_data;
    else if (bus.ramWe) begin
      mem[bus.ramAddr] <= bus.ramWrData;
      wlog_addr.push_back(bus.ramAddr);
      wlog_data.push_back(bus.ramWrData);
    end
    bus.ramRdData <= mem[bus.ramAddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.wrValid = 1'b0; bus.wrAddr = '0; bus.wrData = '0;
    bus.rdValid = 1'b0; bus.rdAddr = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_rdReady", bus.rdReady, 0);
    chk("rst_rdDataValid", bus.rdDataValid, 0);
    chk("rst_rdData", bus.rdData, 0);
    chk("rst_ramWe", bus.ramWe, 0);
    chk("rst_ramAddr", bus.ramAddr, 0);
    chk("rst_ramWrData", bus.ramWrData, 0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wrReady", bus.wrReady, 1);

    tick();
    pre_we = 1'b1; pre_addr = 12'h123; pre_data = 24'hABCDEF;
    tick();
    pre_we = 1'b0;

    // Idle write: RAM write one cycle after acceptance
    bus.wrValid = 1'b1; bus.wrAddr = 12'h010; bus.wrData = 24'h000041;
    @(negedge clk);
    chk("idle_accept_ramWe", bus.ramWe, 0);
    tick();
    bus.wrValid = 1'b0;
    @(negedge clk);
    chk("idle_ramWe", bus.ramWe, 1);
    chk("idle_ramAddr", bus.ramAddr, 12'h010);
    chk("idle_ramWrData", bus.ramWrData, 24'h000041);
    tick();
    @(negedge clk);
    chk("idle_after_ramWe", bus.ramWe, 0);
    chk("idle_hold_ramAddr", bus.ramAddr, 12'h010);
    chk("idle_hold_ramWrData", bus.ramWrData, 24'h000041);

    // Read latency
    tick();
    bus.rdValid = 1'b1; bus.rdAddr = 12'h123;
    @(negedge clk);
    chk("rd_rdReady", bus.rdReady, 1);
    chk("rd_ramAddr", bus.ramAddr, 12'h123);
    chk("rd_ramWe", bus.ramWe, 0);
    tick();
    bus.rdValid = 1'b0;
    @(negedge clk);
    chk("rd_rdDataValid", bus.rdDataValid, 1);
    chk("rd_rdData", bus.rdData, 24'hABCDEF);
    tick();
    @(negedge clk);
    chk("rd_done_rdDataValid", bus.rdDataValid, 0);

    // Starvation guard: one queued write under continuous reads
    tick();
    bus.rdValid = 1'b1; bus.rdAddr = 12'h200;
    bus.wrValid = 1'b1; bus.wrAddr = 12'h300; bus.wrData = 24'h000077;
    @(negedge clk);
    chk("starve_first_read", bus.rdReady, 1);
    tick();
    bus.wrValid = 1'b0;
    reads = 0; n = 0;
    @(negedge clk);
    while (bus.ramWe !== 1'b1 && n < 40) begin
      if (bus.rdReady === 1'b1) reads++;
      tick();
      n++;
      @(negedge clk);
    end
    chk("starve_reads", reads, 15);
    chk("starve_rdReady", bus.rdReady, 0);
    chk("starve_ramAddr", bus.ramAddr, 12'h300);
    chk("starve_ramWrData", bus.ramWrData, 24'h000077);
    tick();
    @(negedge clk);
    chk("starve_resume", bus.rdReady, 1);
    chk("starve_streak", 32'(dut.streak), 0);

    // Full FIFO under continuous reads
    tick();
    base = wlog_addr.size();
    for (int i = 0; i < 8; i++) begin
      bus.wrValid = 1'b1; bus.wrAddr = 12'(12'h400 + i); bus.wrData = 24'(i + 1);
      tick();
    end
    bus.wrAddr = 12'h4FF; bus.wrData = 24'h0000FF;
    @(negedge clk);
    chk("full_wrReady", bus.wrReady, 0);
    n = 0;
    while (bus.ramWe !== 1'b1 && n < 40) begin
      tick();
      n++;
      @(negedge clk);
    end
    chk("full_wait", n, 8);
    chk("full_pop_wrReady", bus.wrReady, 0);
    chk("full_pop_ramAddr", bus.ramAddr, 12'h400);
    tick();
    @(negedge clk);
    chk("full_after_pop_wrReady", bus.wrReady, 1);
    tick();
    bus.wrValid = 1'b0; bus.rdValid = 1'b0;
    repeat (20) tick();
    chk("full_log_size", wlog_addr.size() - base, 9);
    for (int i = 0; i < 8; i++) begin
      if (wlog_addr.size() > base + i)
        chk("full_log_addr", wlog_addr[base + i], 12'(12'h400 + i));
    end
    if (wlog_addr.size() > base + 8)
      chk("full_log_ninth", wlog_addr[base + 8], 12'h4FF);

    // Coalesce: two writes to the same address while reads block the drain
    base = wlog_addr.size();
    bus.rdValid = 1'b1; bus.rdAddr = 12'h123;
    bus.wrValid = 1'b1; bus.wrAddr = 12'h050; bus.wrData = 24'h000011;
    tick();
    bus.wrData = 24'h000022;
    tick();
    bus.wrValid = 1'b0;
`ifdef TEXT_RAM_WR_COALESCE_EN
    chk("coal_count", 32'(dut.u_fifo.count), 1);
`else
    chk("coal_count", 32'(dut.u_fifo.count), 2);
`endif
    bus.rdValid = 1'b0;
    repeat (5) tick();
`ifdef TEXT_RAM_WR_COALESCE_EN
    chk("coal_log_size", wlog_data.size() - base, 1);
    if (wlog_data.size() > base) chk("coal_log_data", wlog_data[base], 24'h000022);
`else
    chk("coal_log_size", wlog_data.size() - base, 2);
    if (wlog_data.size() > base + 1) begin
      chk("coal_log_first", wlog_data[base], 24'h000011);
      chk("coal_log_second", wlog_data[base + 1], 24'h000022);
    end
`endif

    // Asynchronous reset mid-burst with 5 entries queued
    bus.rdValid = 1'b1; bus.rdAddr = 12'h123;
    for (int i = 0; i < 5; i++) begin
      bus.wrValid = 1'b1; bus.wrAddr = 12'(12'h600 + i); bus.wrData = 24'(12'h600 + i);
      tick();
    end
    bus.wrValid = 1'b0;
    chk("mid_count", 32'(dut.u_fifo.count), 5);
    chk("mid_rdDataValid", bus.rdDataValid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_rdReady", bus.rdReady, 0);
    chk("mid_rst_ramWe", bus.ramWe, 0);
    chk("mid_rst_ramAddr", bus.ramAddr, 0);
    chk("mid_rst_ramWrData", bus.ramWrData, 0);
    chk("mid_rst_rdDataValid", bus.rdDataValid, 0);
    chk("mid_rst_rdData", bus.rdData, 0);
    bus.rdValid = 1'b0;
    tick();
    tick();
    base = wlog_addr.size();
    rst = 1'b0;
    repeat (10) tick();
    chk("post_rst_wrReady", bus.wrReady, 1);
    chk("post_rst_count", 32'(dut.u_fifo.count), 0);
    chk("post_rst_no_writes", wlog_addr.size() - base, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
